muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide instructions, sitting in the EX stage beside the ALU.
- It runs when the decoder marks an OP instruction with funct7=0000001, i.e. the case the ALU control path does not cover.
- It owns a shift/add datapath, holds the EX stage via busy_o for the duration of the operation, and presents a single-cycle result at completion.
- Forwarding and the writeback mux treat result_o like the ALU output in the completion cycle.

---
 rtl/muldiv_seq_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_pkg
// Brief    : Shared constants, op/state encodings and signedness helpers for
//            the RV32M multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
package muldiv_seq_pkg;

    localparam int XLEN = 32;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One radix-2 iteration: shift-add multiply or restoring divide
//            on a 64-bit {hi, lo} accumulator.
// Revision : 1.0
// ============================================================================
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   mul_sum_w;
    logic [XLEN:0]   div_rem_w;
    logic            div_ge_w;
    logic [XLEN-1:0] div_sub_w;

    always_comb begin
        mul_sum_w = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Shifted partial remainder can need XLEN+1 bits before the compare.
        div_rem_w = acc_i[2*XLEN-1:XLEN-1];
        div_ge_w  = (div_rem_w >= {1'b0, opnd_i});
        div_sub_w = div_rem_w[XLEN-1:0] - opnd_i;
        if (is_div_i) begin
            if (div_ge_w) begin
                acc_o = {div_sub_w, acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {div_rem_w[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum_w, acc_i[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative RV32M multiply/divide sequencer for the EX stage.
//            MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL*.
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    import muldiv_seq_pkg::*;

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [4:0]        count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    muldiv_op_e        op_in_w;
    logic              a_neg_w, b_neg_w;
    logic [XLEN-1:0]   abs_a_w, abs_b_w;
    logic              step_div_w;
    logic [2*XLEN-1:0] step_w, prod_w;
    logic [XLEN-1:0]   div_word_w, final_w;
    logic              div_zero_w, div_ovf_w;

    assign op_in_w    = muldiv_op_e'(funct3_i);
    assign a_neg_w    = op_a_signed(op_in_w) & op_a_i[XLEN-1];
    assign b_neg_w    = op_b_signed(op_in_w) & op_b_i[XLEN-1];
    assign abs_a_w    = a_neg_w ? -op_a_i : op_a_i;
    assign abs_b_w    = b_neg_w ? -op_b_i : op_b_i;
    assign div_zero_w = op_is_div(op_in_w) && (op_b_i == '0);
    assign div_ovf_w  = ((op_in_w == OP_DIV) || (op_in_w == OP_REM)) &&
                        (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    assign step_div_w = op_is_div(op_q);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a_w, fast_b_w, fast_prod_w;
    assign fast_a_w    = {{XLEN{a_neg_w}}, op_a_i};
    assign fast_b_w    = {{XLEN{b_neg_w}}, op_b_i};
    assign fast_prod_w = fast_a_w * fast_b_w;
`endif

    muldiv_step u_step (
        .is_div_i (step_div_w),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_w)
    );

    // Sign fixup applied to the final step's output.
    always_comb begin
        prod_w     = neg_q ? -step_w : step_w;
        div_word_w = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? step_w[XLEN-1:0]
                                                             : step_w[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      final_w = prod_w[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_w = prod_w[2*XLEN-1:XLEN];
            default:                     final_w = neg_q ? -div_word_w : div_word_w;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_in_w;
                    count_d = 5'd31;
                    // Remainder follows the dividend; everything else follows a^b.
                    neg_d   = ((op_in_w == OP_REM) || (op_in_w == OP_REMU)) ? a_neg_w
                                                                            : (a_neg_w ^ b_neg_w);
                    if (div_zero_w) begin
                        result_d = op_in_w[1] ? op_a_i : '1;
                        state_d  = ST_DONE;
                    end else if (div_ovf_w) begin
                        result_d = op_in_w[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = ST_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op_is_div(op_in_w)) begin
                        result_d = (op_in_w == OP_MUL) ? fast_prod_w[XLEN-1:0]
                                                       : fast_prod_w[2*XLEN-1:XLEN];
                        state_d  = ST_DONE;
                    end
`endif
                    else begin
                        acc_d   = {{XLEN{1'b0}}, op_is_div(op_in_w) ? abs_a_w : abs_b_w};
                        opnd_d  = op_is_div(op_in_w) ? abs_b_w : abs_a_w;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = step_w;
                    count_d = count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        result_d = final_w;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            count_q  <= 5'd0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_IDLE) ? start_i : (state_q == ST_CALC);
    assign done_o   = (state_q == ST_DONE) && !flush_i;
    assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq against a 64-bit arithmetic
//            reference; honours MULDIV_FAST_MUL_EN for expected latency.
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;

    // {funct3, a, b, expected}
    localparam logic [98:0] DIR_VEC [10] = '{
        {3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB},
        {3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
        {3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
        {3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        {3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
        {3'b101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF},
        {3'b111, 32'h00001234, 32'h00000000, 32'h00001234},
        {3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
        {3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
        {3'b001, 32'h80000000, 32'h80000000, 32'h40000000}
    };

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_issue: got %b want 1", busy_o);
        end
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        funct3_i = 3'($urandom());
        op_a_i   = $urandom();
        op_b_i   = $urandom();
    endtask

    // Returns at the falling edge of the done cycle.
    task automatic finish_op(input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        bit seen = 0;
        while (!seen && lat < 60) begin
            @(negedge clk_i);
            lat++;
            if (done_o === 1'b1) begin
                seen = 1;
            end else begin
                checks++;
                if (busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_calc: cycle %0d got %b want 1", lat, busy_o);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles, want latency %0d", lat, exp_lat);
        end else begin
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL latency: got %0d want %0d", lat, exp_lat);
            end
            checks++;
            if (result_o !== exp) begin
                errors++;
                $display("FAIL result: got %h want %h", result_o, exp);
            end
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL busy_done: got %b want 0", busy_o);
            end
            last_res = exp;
        end
    endtask

    task automatic check_hold(input string tag);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || result_o !== last_res) begin
            errors++;
            $display("FAIL %s_hold: done=%b result=%h want done=0 result=%h", tag, done_o, result_o, last_res);
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== last_res) begin
                errors++;
                $display("FAIL %s_quiet: done=%b busy=%b result=%h want 0 0 %h", tag, done_o, busy_o, result_o, last_res);
            end
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        funct3_i = 3'b000;
        op_a_i   = '0;
        op_b_i   = '0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h want 0 0 0", busy_o, done_o, result_o);
        end
        rst_i = 1'b0;
        expect_quiet("post_reset", 2);
    endtask

    task automatic test_directed();
        logic [98:0] v;
        for (int i = 0; i < 10; i++) begin
            v = DIR_VEC[i];
            issue_op(v[98:96], v[95:64], v[63:32]);
            finish_op(v[31:0], ref_latency(v[98:96], v[95:64], v[63:32]));
            check_hold("directed");
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom());
            a  = pick_operand();
            b  = pick_operand();
            issue_op(f3, a, b);
            finish_op(ref_result(f3, a, b), ref_latency(f3, a, b));
            check_hold("random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a2, b2;
        a2 = $urandom();
        b2 = $urandom() | 32'h1;
        issue_op(3'b101, 32'hDEADBEEF, 32'h00000013);
        finish_op(ref_result(3'b101, 32'hDEADBEEF, 32'h00000013), ref_latency(3'b101, 32'hDEADBEEF, 32'h00000013));
        start_i  = 1'b1;
        funct3_i = 3'b110;
        op_a_i   = a2;
        op_b_i   = b2;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_busy: got %b want 0", busy_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || result_o !== last_res) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b result=%h want 1 0 %h", busy_o, done_o, result_o, last_res);
        end
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        finish_op(ref_result(3'b110, a2, b2), ref_latency(3'b110, a2, b2));
    endtask

    task automatic test_flush();
        logic [31:0] a, b;
        a = $urandom();
        b = $urandom() | 32'h1;
        issue_op(3'b101, a, b);
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        expect_quiet("flush", 40);
        // Flush coinciding with start: a divide-by-zero would otherwise finish next cycle.
        @(negedge clk_i);
        start_i  = 1'b1;
        flush_i  = 1'b1;
        funct3_i = 3'b101;
        op_a_i   = a;
        op_b_i   = 32'h0;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        expect_quiet("flush_start", 3);
        a = pick_operand();
        b = pick_operand();
        issue_op(3'b000, a, b);
        finish_op(ref_result(3'b000, a, b), ref_latency(3'b000, a, b));
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        a = $urandom();
        b = $urandom();
        issue_op(3'b001, a, b);
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0", busy_o, done_o, result_o);
        end
        last_res = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_quiet("reset_mid", 40);
        a = pick_operand();
        b = $urandom_range(1, 1000);
        issue_op(3'b110, a, b);
        finish_op(ref_result(3'b110, a, b), ref_latency(3'b110, a, b));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
